// File: rtl/psa_pkg.sv
// -----------------------------------------------------------------------------
// psa_pkg
// Shared definitions for the packed sub-word adder pipeline:
//   DATA_W_DEF / LANE_W_DEF : default operand and lane widths
//   lane_max / lane_min     : saturation constants for a signed lane of width w
//                             (returned zero-extended to 32 bits, caller truncates)
// -----------------------------------------------------------------------------
package psa_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned LANE_W_DEF = 4;

    // Largest positive two's-complement value of a w-bit lane: 0111..1
    function automatic logic [31:0] lane_max(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    // Most negative two's-complement value of a w-bit lane: 1000..0
    function automatic logic [31:0] lane_min(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

endpackage

// File: rtl/psa_pipe_if.sv
// -----------------------------------------------------------------------------
// psa_pipe_if
// Bundles the input handshake, operands, output handshake, result and sticky
// error signals of psa_pipe.
//   master : producer/consumer side (drives operands, out_ready, clr_sticky)
//   slave  : the pipeline itself
// -----------------------------------------------------------------------------
interface psa_pipe_if
    import psa_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LANE_W = LANE_W_DEF
);
    localparam int unsigned LANES = DATA_W / LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic              sat_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic [LANES-1:0]  lane_ovf;
    logic              error;
    logic              sticky_err;
    logic              clr_sticky;

    modport master (
        output in_valid, a, b, sub, sat_en, out_ready, clr_sticky,
        input  in_ready, out_valid, sum, lane_ovf, error, sticky_err
    );

    modport slave (
        input  in_valid, a, b, sub, sat_en, out_ready, clr_sticky,
        output in_ready, out_valid, sum, lane_ovf, error, sticky_err
    );

endinterface

// File: rtl/psa_lane.sv
// -----------------------------------------------------------------------------
// psa_lane
// One signed LANE_W-bit add/subtract lane with overflow detect and optional
// saturation. Purely combinational.
//   a, b   : lane operands (two's complement)
//   sub    : 0 = a+b, 1 = a-b
//   sat_en : 1 = clamp on overflow, 0 = wrap
//   res    : lane result
//   ovf    : true signed overflow of a op b
// -----------------------------------------------------------------------------
module psa_lane
    import psa_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sub,
    input  logic              sat_en,
    output logic [LANE_W-1:0] res,
    output logic              ovf
);

    localparam logic [LANE_W-1:0] SAT_MAX = LANE_W'(lane_max(LANE_W));
    localparam logic [LANE_W-1:0] SAT_MIN = LANE_W'(lane_min(LANE_W));

    logic [LANE_W:0] a_ext_s;
    logic [LANE_W:0] b_ext_s;
    logic [LANE_W:0] full_s;

    // One extra sign bit makes the exact result representable; overflow is
    // when the top two bits disagree, and the top bit gives the true sign.
    always_comb begin
        a_ext_s = {a[LANE_W-1], a};
        b_ext_s = {b[LANE_W-1], b};
        if (sub) begin
            full_s = a_ext_s - b_ext_s;
        end else begin
            full_s = a_ext_s + b_ext_s;
        end
        ovf = full_s[LANE_W] ^ full_s[LANE_W-1];
        if (ovf && sat_en) begin
            if (full_s[LANE_W]) begin
                res = SAT_MIN;
            end else begin
                res = SAT_MAX;
            end
        end else begin
            res = full_s[LANE_W-1:0];
        end
    end

endmodule

// File: rtl/psa_pipe.sv
// -----------------------------------------------------------------------------
// psa_pipe
// Two-stage valid/ready pipeline performing independent signed add/subtract
// on LANES = DATA_W/LANE_W packed sub-words (lane 0 in the LSBs).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, discards everything in flight
//   bus : psa_pipe_if slave modport
//         in_valid/in_ready, a, b, sub, sat_en   -> operand side (S1 capture)
//         out_valid/out_ready, sum, lane_ovf,    -> result side (S2 holds)
//         error, sticky_err, clr_sticky
// -----------------------------------------------------------------------------
module psa_pipe
    import psa_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LANE_W = LANE_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    psa_pipe_if.slave  bus
);

    localparam int unsigned LANES = DATA_W / LANE_W;

    // Stage 1: captured operands
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q,     s1_a_d;
    logic [DATA_W-1:0] s1_b_q,     s1_b_d;
    logic              s1_sub_q,   s1_sub_d;
    logic              s1_sat_q,   s1_sat_d;
    // Stage 2: computed result
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_sum_q,   s2_sum_d;
    logic [LANES-1:0]  s2_ovf_q,   s2_ovf_d;
    logic              s2_err_q,   s2_err_d;
    logic              sticky_q,   sticky_d;

    logic              s2_adv_s;
    logic              s1_adv_s;
    logic              in_ready_s;
    logic              in_acc_s;
    logic              out_acc_s;
    logic [DATA_W-1:0] lane_res_s;
    logic [LANES-1:0]  lane_ovf_s;

    // Per-lane arithmetic on the S1 operands
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psa_lane #(.LANE_W(LANE_W)) u_lane (
            .a      (s1_a_q[g*LANE_W +: LANE_W]),
            .b      (s1_b_q[g*LANE_W +: LANE_W]),
            .sub    (s1_sub_q),
            .sat_en (s1_sat_q),
            .res    (lane_res_s[g*LANE_W +: LANE_W]),
            .ovf    (lane_ovf_s[g])
        );
    end

    // Handshake: S2 may take new data when empty or being drained;
    // S1 may take new data when empty or moving into S2.
    always_comb begin
        s2_adv_s   = !s2_valid_q || bus.out_ready;
        s1_adv_s   = s1_valid_q && s2_adv_s;
        in_ready_s = !s1_valid_q || s2_adv_s;
        in_acc_s   = bus.in_valid && in_ready_s;
        out_acc_s  = s2_valid_q && bus.out_ready;
    end

    // Next-state for both stages and the sticky flag
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sub_d   = s1_sub_q;
        s1_sat_d   = s1_sat_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_ovf_d   = s2_ovf_q;
        s2_err_d   = s2_err_q;

        if (in_acc_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.a;
            s1_b_d     = bus.b;
            s1_sub_d   = bus.sub;
            s1_sat_d   = bus.sat_en;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s1_adv_s) begin
            s2_valid_d = 1'b1;
            s2_sum_d   = lane_res_s;
            s2_ovf_d   = lane_ovf_s;
            s2_err_d   = |lane_ovf_s;
        end else if (out_acc_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        // Setting on a consumed overflowing result takes priority over clear
        if (out_acc_s && s2_err_q) begin
            sticky_d = 1'b1;
        end else if (bus.clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= {DATA_W{1'b0}};
            s1_b_q     <= {DATA_W{1'b0}};
            s1_sub_q   <= 1'b0;
            s1_sat_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= {DATA_W{1'b0}};
            s2_ovf_q   <= {LANES{1'b0}};
            s2_err_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_sub_q   <= s1_sub_d;
            s1_sat_q   <= s1_sat_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_err_q   <= s2_err_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = s2_valid_q;
    assign bus.sum        = s2_sum_q;
    assign bus.lane_ovf   = s2_ovf_q;
    assign bus.error      = s2_err_q;
    assign bus.sticky_err = sticky_q;

endmodule

// File: tb/tb_psa_pipe.sv
// -----------------------------------------------------------------------------
// tb_psa_pipe
// Scoreboard bench for psa_pipe (DATA_W=16, LANE_W=4). The driver pushes the
// hand-computed expected result when an operand set is accepted; a monitor
// pops and compares on every consumed output.
// -----------------------------------------------------------------------------
module tb_psa_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    psa_pipe_if #(.DATA_W(16), .LANE_W(4)) bus ();

    psa_pipe #(.DATA_W(16), .LANE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] sum;
        logic [3:0]  ovf;
        logic        err;
        int          issue;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        logic [15:0] es;
        logic [3:0]  eo;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   lat_mode = 1'b0;
    logic        held_v = 1'b0;
    logic [15:0] held_sum = 16'd0;

    // Cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int   budget;
        exp_t e;
        budget       = 40;
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.sub      = v.sub;
        bus.sat_en   = v.sat;
        @(negedge clk);
        while (!bus.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        end else begin
            e.sum   = v.es;
            e.ovf   = v.eo;
            e.err   = |v.eo;
            e.issue = cyc;
            e.lat   = lat_mode;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compares every consumed output, checks hold-while-stalled
    always @(negedge clk) begin
        if (rst) begin
            held_v <= 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("hold_sum", {16'd0, bus.sum}, {16'd0, held_sum});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got sum %0h, required no output", bus.sum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sum", {16'd0, bus.sum}, {16'd0, e.sum});
                    chk("lane_ovf", {28'd0, bus.lane_ovf}, {28'd0, e.ovf});
                    chk("error", {31'd0, bus.error}, {31'd0, e.err});
                    if (e.lat) begin
                        chk("latency", cyc - e.issue, 32'd2);
                    end
                end
            end
            held_v   <= bus.out_valid && !bus.out_ready;
            held_sum <= bus.sum;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9] = '{
        '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 4'b0000},
        '{16'h5678, 16'h8765, 1'b0, 1'b1, 16'hD77D, 4'b0110},
        '{16'h5678, 16'h8765, 1'b0, 1'b0, 16'hDDDD, 4'b0110},
        '{16'h8000, 16'h1000, 1'b1, 1'b1, 16'h8000, 4'b1000},
        '{16'h8000, 16'h1000, 1'b1, 1'b0, 16'h7000, 4'b1000},
        '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h800F, 4'b0000},
        '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFF0, 4'b0000},
        '{16'h7777, 16'h1111, 1'b0, 1'b1, 16'h7777, 4'b1111},
        '{16'h8888, 16'h1111, 1'b1, 1'b1, 16'h8888, 4'b1111}
    };

    vec_t bp_vecs[3] = '{
        '{16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 4'b0000},
        '{16'h7777, 16'h1111, 1'b0, 1'b0, 16'h8888, 4'b1111},
        '{16'h8888, 16'h1111, 1'b1, 1'b1, 16'h8888, 4'b1111}
    };

    initial begin
        int budget;
        bus.in_valid   = 1'b0;
        bus.a          = 16'd0;
        bus.b          = 16'd0;
        bus.sub        = 1'b0;
        bus.sat_en     = 1'b0;
        bus.out_ready  = 1'b1;
        bus.clr_sticky = 1'b0;
        rst            = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, bus.sum}, 32'd0);
        chk("rst_lane_ovf", {28'd0, bus.lane_ovf}, 32'd0);
        chk("rst_error", {31'd0, bus.error}, 32'd0);
        chk("rst_sticky", {31'd0, bus.sticky_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors, full throughput, latency checked
        lat_mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i]);
        end
        lat_mode = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Backpressure: two accepted, third held off until out_ready returns
        bus.out_ready = 1'b0;
        send(bp_vecs[0]);
        send(bp_vecs[1]);
        fork
            send(bp_vecs[2]);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
                end
                chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drained", sb.size(), 32'd0);

        // Sticky: clear any earlier state, then set-wins-over-clear
        bus.clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", {31'd0, bus.sticky_err}, 32'd0);
        @(posedge clk);
        #1;
        send(vecs[1]);
        budget = 10;
        @(negedge clk);
        while (!bus.out_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("sticky_out_wait", {31'd0, bus.out_valid}, 32'd1);
        bus.clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sticky_set_wins", {31'd0, bus.sticky_err}, 32'd1);
        @(posedge clk);
        #1;
        bus.clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_clr_alone", {31'd0, bus.sticky_err}, 32'd0);
        @(posedge clk);
        #1;

        // Reset with two sets in flight
        bus.out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        #2;
        chk("flight_out_valid_pre", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("flight_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flight_rst_sum", {16'd0, bus.sum}, 32'd0);
        chk("flight_rst_lane_ovf", {28'd0, bus.lane_ovf}, 32'd0);
        sb.delete();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flight_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psa_pipe.md
PSA_PIPE -- requirements
Module: psa_pipe

Interface
REQ-001 Parameter DATA_W, default 16, total operand width.
REQ-002 Parameter LANE_W, default 4, width of one signed sub-word lane; DATA_W SHALL be a multiple of LANE_W, and LANES = DATA_W/LANE_W.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand set on a, b, sub, sat_en is valid.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 a  input  DATA_W  operand A, packed lanes, lane 0 in the LSBs.
REQ-008 b  input  DATA_W  operand B, packed lanes.
REQ-009 sub  input  1  0 = per-lane A+B, 1 = per-lane A-B.
REQ-010 sat_en  input  1  1 = saturate overflowing lanes, 0 = wrap.
REQ-011 out_valid  output  1  result on sum, lane_ovf and error is valid.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 sum  output  DATA_W  per-lane result.
REQ-014 lane_ovf  output  LANES  per-lane signed overflow flags for the current result.
REQ-015 error  output  1  OR-reduction of lane_ovf.
REQ-016 sticky_err  output  1  latched "some consumed result overflowed".
REQ-017 clr_sticky  input  1  synchronous clear of sticky_err.

Function
REQ-018 Each lane SHALL be an independent LANE_W-bit two's-complement add or subtract; no carry or borrow SHALL cross lane boundaries.
REQ-019 Lane overflow SHALL be true signed overflow (true result outside [-2^(LANE_W-1), 2^(LANE_W-1)-1]).
REQ-020 With sat_en=1, an overflowing lane SHALL produce 0111..1 on positive overflow and 1000..0 on negative overflow; with sat_en=0 it SHALL produce the wrapped low LANE_W bits; lane_ovf SHALL be set in both modes.
REQ-021 The pipeline SHALL have two register stages: S1 captures a, b, sub, sat_en; S2 holds the computed sum and lane_ovf. Latency SHALL be 2 cycles from in_valid&&in_ready to out_valid when out_ready stays 1.
REQ-022 Throughput SHALL be one operand set per cycle when out_ready=1.
REQ-023 A transfer SHALL occur only on valid&&ready at the same edge; outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 A stage SHALL advance when it is empty or the stage downstream is advancing or empty; in_ready SHALL equal "S1 empty, or S1 advancing into S2".
REQ-025 With out_ready=0, the block SHALL hold at most two operand sets, then deassert in_ready.
REQ-026 sticky_err SHALL set on out_valid&&out_ready&&error; clr_sticky SHALL clear it; if both occur in one cycle, set SHALL win.

Reset
REQ-027 rst SHALL immediately clear both stage valid bits, so out_valid=0, sum=0, lane_ovf=0, error=0 and sticky_err=0; in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-028 Reset mid-operation SHALL discard all in-flight operand sets; no result for them SHALL appear afterwards.

Structure
REQ-029 Default widths and the saturation-constant helpers (max/min per LANE_W) SHALL live in shared package psa_pkg.
REQ-030 Per-lane arithmetic SHALL be a combinational sub-module psa_lane (LANE_W parameter; a, b, sub, sat_en in; res, ovf out), instantiated LANES times by generate.

Verification (DATA_W=16, LANE_W=4, out_ready=1 unless stated)
REQ-031 a=1234, b=4321, add, sat -> 2 cycles later: sum=5555, lane_ovf=0000, error=0.
REQ-032 a=5678, b=8765, add, sat -> sum=D77D, lane_ovf=0110, error=1; the same operands with sat_en=0 -> sum=DDDD, lane_ovf=0110.
REQ-033 a=8000, b=1000, sub, sat -> sum=8000, lane_ovf=1000; a=8000, b=0001, sub -> sum=800F, lane_ovf=0000; a=FFFF, b=0001, add -> sum=FFF0, lane_ovf=0000.
REQ-034 out_ready=0 with 3 back-to-back inputs -> in_ready=0 after 2 accepts; after out_ready=1, results emerge in order with none dropped or duplicated.
REQ-035 Consume an overflowing result while clr_sticky=1 -> sticky_err=1; clr_sticky alone on the next cycle -> sticky_err=0.
REQ-036 Assert rst with 2 sets in flight -> out_valid=0 immediately, and no stale result after release.
